// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU-sharing controller: FSM state encoding,
// ALU op-code constants and response flag bit positions.
package alu_share_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_PASS_B = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_ADC    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_SBC    = 4'd5;
  localparam logic [3:0] OP_INC    = 4'd6;
  localparam logic [3:0] OP_DEC    = 4'd7;
  localparam logic [3:0] OP_CMP    = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_OR     = 4'd10;
  localparam logic [3:0] OP_XOR    = 4'd11;
  localparam logic [3:0] OP_NOT    = 4'd12;
  localparam logic [3:0] OP_SHL    = 4'd13;
  localparam logic [3:0] OP_SHR    = 4'd14;
  localparam logic [3:0] OP_NOP    = 4'd15;

  localparam int unsigned FLAG_COUT  = 3;
  localparam int unsigned FLAG_OFLOW = 2;
  localparam int unsigned FLAG_NTIVE = 1;
  localparam int unsigned FLAG_ZERO  = 0;

  // Arithmetic ops whose carry-out feeds the requester's saved carry.
  function automatic logic op_uses_carry(input int unsigned op);
    return (op >= 32'(OP_ADD)) && (op <= 32'(OP_DEC));
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter. The pointer names the requester that wins
// when both request; it moves to the other requester on each advance strobe.
module alu_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       adv,
  input  logic       adv_id,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt_id = req[1];
    if (req == 2'b11) gnt_id = ptr_q;
    gnt = '0;
    if (en && (req != 2'b00)) gnt = gnt_id ? 2'b10 : 2'b01;
  end

  // Pointer moves to the requester that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = ~adv_id;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters.
// IDLE grants one request and latches its operands, EXEC captures the ALU
// result one cycle later, RESP holds the result until the consumer takes it.
// Optional feature: define ALU_SHARE_CARRY_EN to keep a saved carry per
// requester that drives alu_cin and is refreshed by ops 2-7.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned DW  = 64,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_o,
  output logic [3:0]     rsp_flags,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_s,
  output logic           alu_cin,
  input  logic [DW-1:0]  alu_o,
  input  logic           alu_cout,
  input  logic           alu_oflow,
  input  logic           alu_ntive,
  input  logic           alu_zero
);

  state_t         state_q, state_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic           id_q, id_d;
  logic [DW-1:0]  rsp_o_q, rsp_o_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       arb_en;
  logic       rsp_hs;

  // Ready is suppressed while reset is asserted even though the FSM sits in IDLE.
  assign arb_en = (state_q == ST_IDLE) && rst_n;
  assign rsp_hs = rsp_valid && rsp_ready;

  alu_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .en     (arb_en),
    .adv    (rsp_hs),
    .adv_id (id_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_s     = op_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_o     = rsp_o_q;
  assign rsp_flags = rsp_flags_q;

  // FSM next state, request capture and result capture.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_o_d     = rsp_o_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          id_d    = gnt_id;
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          op_d    = gnt_id ? req1_op : req0_op;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_o_d                 = alu_o;
        rsp_flags_d[FLAG_COUT]  = alu_cout;
        rsp_flags_d[FLAG_OFLOW] = alu_oflow;
        rsp_flags_d[FLAG_NTIVE] = alu_ntive;
        rsp_flags_d[FLAG_ZERO]  = alu_zero;
        state_d                 = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_o_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_o_q     <= rsp_o_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

`ifdef ALU_SHARE_CARRY_EN
  logic [1:0] carry_q, carry_d;

  // Saved carry of the executing requester follows alu_cout for ops 2-7.
  always_comb begin
    carry_d = carry_q;
    if ((state_q == ST_EXEC) && op_uses_carry(32'(op_q))) carry_d[id_q] = alu_cout;
  end

  // Per-requester carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= '0;
    else        carry_q <= carry_d;
  end

  assign alu_cin = carry_q[id_q];
`else
  assign alu_cin = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU attached.
module tb_alu_share_ctrl;

  localparam int DW  = 64;
  localparam int OPW = 4;

  logic           clk, rst_n;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0]  rsp_o;
  logic [3:0]     rsp_flags;
  logic [DW-1:0]  alu_a, alu_b, alu_o;
  logic [OPW-1:0] alu_s;
  logic           alu_cin, alu_cout, alu_oflow, alu_ntive, alu_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_ptr;
`ifdef ALU_SHARE_CARRY_EN
  logic [1:0] mdl_carry;
`endif
  logic [DW-1:0] ra[2], rb[2];
  logic [3:0]    rop[2];

  int            g, gw, rid, lat;
  bit            st, to;
  logic [DW-1:0] o, eo;
  logic [3:0]    fl, ef;

  alu_share_ctrl #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_o(rsp_o), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_o(alu_o), .alu_cout(alu_cout), .alu_oflow(alu_oflow), .alu_ntive(alu_ntive), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {cout, oflow, ntive, zero, result}.
  function automatic logic [DW+3:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [3:0] s, input logic cin);
    logic [DW:0]   w;
    logic [DW-1:0] r, bb;
    logic          c, v, n, z, arith;
    w = '0; bb = b; r = '0; c = 1'b0; v = 1'b0;
    arith = (s >= 4'd2) && (s <= 4'd8);
    case (s)
      4'd0: r = a;
      4'd1: r = b;
      4'd2: w = {1'b0, a} + {1'b0, bb};
      4'd3: w = {1'b0, a} + {1'b0, bb} + (DW+1)'(cin);
      4'd4, 4'd8: begin bb = ~b; w = {1'b0, a} + {1'b0, bb} + (DW+1)'(1); end
      4'd5: begin bb = ~b; w = {1'b0, a} + {1'b0, bb} + (DW+1)'(cin); end
      4'd6: begin bb = DW'(1); w = {1'b0, a} + {1'b0, bb}; end
      4'd7: begin bb = '1; w = {1'b0, a} + {1'b0, bb}; end
      4'd9:  r = a & b;
      4'd10: r = a | b;
      4'd11: r = a ^ b;
      4'd12: r = ~a;
      4'd13: r = a << 1;
      4'd14: r = a >> 1;
      default: r = '0;
    endcase
    if (arith) begin
      r = w[DW-1:0];
      c = w[DW];
      v = (a[DW-1] == bb[DW-1]) && (r[DW-1] != a[DW-1]);
    end
    n = r[DW-1];
    z = (r == '0);
    if (s == 4'd8) r = '0;
    return {c, v, n, z, r};
  endfunction

  always_comb {alu_cout, alu_oflow, alu_ntive, alu_zero, alu_o} = alu_fn(alu_a, alu_b, alu_s, alu_cin);

  function automatic logic [DW-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(DW-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic model_reset();
    mdl_ptr = 0;
`ifdef ALU_SHARE_CARRY_EN
    mdl_carry = '0;
`endif
  endtask

  // Transaction-level reference: result of one served request, carry and pointer bookkeeping.
  task automatic model_txn(input int id, output logic [DW-1:0] ro, output logic [3:0] rf);
    logic [DW+3:0] r;
    logic          cin;
    cin = 1'b0;
`ifdef ALU_SHARE_CARRY_EN
    cin = mdl_carry[id];
`endif
    r  = alu_fn(ra[id], rb[id], rop[id], cin);
    ro = r[DW-1:0];
    rf = r[DW+3:DW];
`ifdef ALU_SHARE_CARRY_EN
    if (rop[id] >= 4'd2 && rop[id] <= 4'd7) mdl_carry[id] = r[DW+3];
`endif
    mdl_ptr = 1 - id;
  endtask

  task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op);
    ra[id] = a; rb[id] = b; rop[id] = op;
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Observes one transaction: grant, latency, response, optional stall with stability sampling.
  task automatic serve(input int stall, output int gid, output int gwait, output int rsid,
                       output logic [DW-1:0] ro, output logic [3:0] rf, output int lt,
                       output bit stable, output bit tmo);
    tmo = 0; gid = -1; gwait = -1; rsid = -1; ro = '0; rf = '0; lt = 0; stable = 1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req0_ready || req1_ready) begin
        gid = (req0_ready && req1_ready) ? 2 : (req1_ready ? 1 : 0);
        gwait = i;
        break;
      end
      @(negedge clk);
    end
    if (gid < 0) tmo = 1;
    else begin
      @(negedge clk);
      if (gid != 1) req0_valid = 1'b0;
      if (gid != 0) req1_valid = 1'b0;
      lt = 1;
      while (rsp_valid !== 1'b1 && lt < 20) begin @(negedge clk); lt++; end
      if (rsp_valid !== 1'b1) tmo = 1;
      else begin
        rsid = int'(rsp_id); ro = rsp_o; rf = rsp_flags;
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          if (rsp_valid !== 1'b1 || rsp_o !== ro || rsp_flags !== rf || rsp_id !== rsid[0] ||
              req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    set_req(0, 64'h1234, 64'h5678, 4'd2);
    set_req(1, 64'h9abc, 64'hdef0, 4'd3);
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid actual=%b required=0", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id actual=%b required=0", rsp_id); end
    n_checks++; if (rsp_o !== '0) begin n_fail++; $display("FAIL reset_rsp_o actual=%0h required=0", rsp_o); end
    n_checks++; if (rsp_flags !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_flags actual=%b required=0000", rsp_flags); end
    n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready actual=%b required=00", {req1_ready, req0_ready}); end
    n_checks++; if (alu_a !== '0 || alu_b !== '0 || alu_s !== '0) begin n_fail++; $display("FAIL reset_alu_in actual=%0h/%0h/%0h required=0/0/0", alu_a, alu_b, alu_s); end
    n_checks++; if (alu_cin !== 1'b0) begin n_fail++; $display("FAIL reset_alu_cin actual=%b required=0", alu_cin); end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_simultaneous();
    int first;
    for (int p = 0; p < 2; p++) begin
      set_req(0, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
      set_req(1, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
      for (int k = 0; k < 2; k++) begin
        first = (k == 0) ? 0 : 1;
        model_txn(first, eo, ef);
        serve(0, g, gw, rid, o, fl, lat, st, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL sim_timeout pair=%0d k=%0d actual=timeout required=response", p, k); end
        n_checks++; if (g != first) begin n_fail++; $display("FAIL sim_grant pair=%0d k=%0d actual=%0d required=%0d", p, k, g, first); end
        n_checks++; if (rid != first || o !== eo || fl !== ef) begin n_fail++; $display("FAIL sim_rsp pair=%0d k=%0d actual=%0d/%0h/%b required=%0d/%0h/%b", p, k, rid, o, fl, first, eo, ef); end
        if (k == 1) begin
          n_checks++; if (gw != 0) begin n_fail++; $display("FAIL sim_issue_gap actual=%0d required=0", gw); end
        end
      end
    end
  endtask

  task automatic test_single();
    set_req(0, 64'd5, 64'd7, 4'd2);
    model_txn(0, eo, ef);
    serve(0, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout actual=timeout required=response"); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_latency actual=%0d required=2", lat); end
    n_checks++; if (o !== 64'd12) begin n_fail++; $display("FAIL single_o actual=%0h required=c", o); end
    n_checks++; if (rid != 0) begin n_fail++; $display("FAIL single_id actual=%0d required=0", rid); end
    n_checks++; if (fl !== 4'b0000) begin n_fail++; $display("FAIL single_flags actual=%b required=0000", fl); end
    n_checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_s !== 4'd2) begin n_fail++; $display("FAIL single_alu_hold actual=%0h/%0h/%0h required=5/7/2", alu_a, alu_b, alu_s); end
  endtask

  task automatic test_backpressure();
    int first;
    set_req(0, rnd_operand(), rnd_operand(), 4'd2);
    set_req(1, rnd_operand(), rnd_operand(), 4'd4);
    first = mdl_ptr;
    model_txn(first, eo, ef);
    serve(10, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout actual=timeout required=response"); end
    n_checks++; if (g != first) begin n_fail++; $display("FAIL bp_grant actual=%0d required=%0d", g, first); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL bp_stable actual=changed required=stable"); end
    n_checks++; if (o !== eo || fl !== ef) begin n_fail++; $display("FAIL bp_rsp actual=%0h/%b required=%0h/%b", o, fl, eo, ef); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle actual=%b required=0", rsp_valid); end
    model_txn(1 - first, eo, ef);
    serve(0, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to || g != 1 - first || gw != 0) begin n_fail++; $display("FAIL bp_second actual=%0d/%0d required=%0d/0", g, gw, 1 - first); end
    n_checks++; if (o !== eo || fl !== ef) begin n_fail++; $display("FAIL bp_second_rsp actual=%0h/%b required=%0h/%b", o, fl, eo, ef); end
  endtask

  task automatic test_compare();
    set_req(0, 64'd3, 64'd9, 4'd8);
    model_txn(0, eo, ef);
    serve(0, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to || o !== '0) begin n_fail++; $display("FAIL cmp_lt_o actual=%0h required=0", o); end
    n_checks++; if (fl[1] !== 1'b1 || fl[0] !== 1'b0) begin n_fail++; $display("FAIL cmp_lt_nz actual=%b%b required=10", fl[1], fl[0]); end
    n_checks++; if (fl !== ef) begin n_fail++; $display("FAIL cmp_lt_flags actual=%b required=%b", fl, ef); end
    set_req(1, 64'd9, 64'd9, 4'd8);
    model_txn(1, eo, ef);
    serve(0, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to || fl[1] !== 1'b0 || fl[0] !== 1'b1) begin n_fail++; $display("FAIL cmp_eq_nz actual=%b%b required=01", fl[1], fl[0]); end
    n_checks++; if (fl !== ef || o !== '0) begin n_fail++; $display("FAIL cmp_eq_flags actual=%b/%0h required=%b/0", fl, o, ef); end
  endtask

  task automatic test_carry_chain();
    logic [DW-1:0] exp_adc;
`ifdef ALU_SHARE_CARRY_EN
    exp_adc = DW'(1);
`else
    exp_adc = '0;
`endif
    do_reset();
    set_req(1, '1, 64'd1, 4'd2);
    model_txn(1, eo, ef);
    serve(0, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to || o !== '0 || fl !== 4'b1001) begin n_fail++; $display("FAIL carry_add actual=%0h/%b required=0/1001", o, fl); end
    set_req(1, '0, '0, 4'd3);
    model_txn(1, eo, ef);
    serve(0, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to || o !== exp_adc) begin n_fail++; $display("FAIL carry_adc_req1 actual=%0h required=%0h", o, exp_adc); end
    n_checks++; if (o !== eo || fl !== ef) begin n_fail++; $display("FAIL carry_adc_req1_model actual=%0h/%b required=%0h/%b", o, fl, eo, ef); end
    set_req(0, '0, '0, 4'd3);
    model_txn(0, eo, ef);
    serve(0, g, gw, rid, o, fl, lat, st, to);
    n_checks++; if (to || o !== '0 || rid != 0) begin n_fail++; $display("FAIL carry_adc_req0 actual=%0h/%0d required=0/0", o, rid); end
  endtask

  task automatic test_random();
    logic [1:0] pat;
    int         nsrv, first, exp_id;
    for (int it = 0; it < 30; it++) begin
      pat = 2'($urandom_range(1, 3));
      for (int id = 0; id < 2; id++)
        if (pat[id]) set_req(id, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
      nsrv  = (pat == 2'b11) ? 2 : 1;
      first = (pat == 2'b11) ? mdl_ptr : ((pat == 2'b01) ? 0 : 1);
      for (int k = 0; k < nsrv; k++) begin
        exp_id = (k == 0) ? first : 1 - first;
        model_txn(exp_id, eo, ef);
        serve($urandom_range(0, 3), g, gw, rid, o, fl, lat, st, to);
        n_checks++; if (to || g != exp_id || rid != exp_id) begin n_fail++; $display("FAIL rnd_id it=%0d k=%0d actual=%0d/%0d required=%0d", it, k, g, rid, exp_id); end
        n_checks++; if (o !== eo || fl !== ef) begin n_fail++; $display("FAIL rnd_rsp it=%0d k=%0d op=%0d actual=%0h/%b required=%0h/%b", it, k, rop[exp_id], o, fl, eo, ef); end
        n_checks++; if (lat != 2 || !st) begin n_fail++; $display("FAIL rnd_timing it=%0d k=%0d actual=lat%0d/stable%0d required=lat2/stable1", it, k, lat, st); end
      end
    end
  endtask

  task automatic test_reset_in_exec();
    bit got, quiet;
    for (int r = 0; r < 2; r++) begin
      set_req(0, rnd_operand(), rnd_operand(), 4'd2);
      model_txn(0, eo, ef);
      serve(0, g, gw, rid, o, fl, lat, st, to);
      set_req(1, 64'd10, 64'd20, 4'd2);
      #1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
        if (req1_ready) begin got = 1; break; end
        @(negedge clk);
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL rie_grant round=%0d actual=no_grant required=grant", r); end
      @(negedge clk);
      rst_n = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      quiet = 1;
      repeat (5) begin @(negedge clk); if (rsp_valid !== 1'b0) quiet = 0; end
      rsp_ready = 1'b0;
      n_checks++; if (!quiet) begin n_fail++; $display("FAIL rie_no_rsp round=%0d actual=rsp_valid required=quiet", r); end
      if (r == 0) begin
        set_req(1, rnd_operand(), rnd_operand(), 4'd3);
        model_txn(1, eo, ef);
        serve(0, g, gw, rid, o, fl, lat, st, to);
        n_checks++; if (to || g != 1 || rid != 1 || lat != 2) begin n_fail++; $display("FAIL rie_req1 actual=%0d/%0d/%0d required=1/1/2", g, rid, lat); end
        n_checks++; if (o !== eo || fl !== ef) begin n_fail++; $display("FAIL rie_req1_rsp actual=%0h/%b required=%0h/%b", o, fl, eo, ef); end
      end else begin
        set_req(0, rnd_operand(), rnd_operand(), 4'd11);
        set_req(1, rnd_operand(), rnd_operand(), 4'd9);
        model_txn(0, eo, ef);
        serve(0, g, gw, rid, o, fl, lat, st, to);
        n_checks++; if (to || g != 0) begin n_fail++; $display("FAIL rie_ptr actual=%0d required=0", g); end
        model_txn(1, eo, ef);
        serve(0, g, gw, rid, o, fl, lat, st, to);
        n_checks++; if (to || g != 1 || o !== eo) begin n_fail++; $display("FAIL rie_ptr_second actual=%0d/%0h required=1/%0h", g, o, eo); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_simultaneous();
    test_single();
    test_backpressure();
    test_compare();
    test_carry_chain();
    test_random();
    test_reset_in_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=time_limit required=completion");
    $fatal(1, "time limit");
  end

endmodule
